// File: rtl/vproc_pkg.sv
// Shared vector-core definitions: op unit encoding, vreg mask bundle and
// the dispatcher's state and hazard helper.
package vproc_pkg;

    localparam int unsigned UNIT_CNT = 6;

    typedef enum logic [2:0] {
        UNIT_LSU  = 3'd0,
        UNIT_ALU  = 3'd1,
        UNIT_MUL  = 3'd2,
        UNIT_SLD  = 3'd3,
        UNIT_ELEM = 3'd4,
        UNIT_CFG  = 3'd5
    } op_unit;

    // Kept in the low bits of each queued entry so the FIFO tap can OR them.
    typedef struct packed {
        logic [31:0] wr_mask;
        logic [31:0] rd_mask;
    } vreg_masks_t;

    typedef enum logic [0:0] {
        DISP_ARB = 1'b0
    } disp_state_e;

    // RAW on reads, WAW/WAR on writes against what the pipelines still hold.
    function automatic logic vreg_hazard(input vreg_masks_t m,
                                         input logic [31:0] pend_wr,
                                         input logic [31:0] pend_rd);
        return (|(m.rd_mask & pend_wr)) | (|(m.wr_mask & (pend_wr | pend_rd)));
    endfunction

endpackage

// File: rtl/vproc_dispatch_fifo.sv
// Generic synchronous FIFO with full/empty/count and a combinational OR of the
// low TAP_W bits of every valid entry.
module vproc_dispatch_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAP_W  = 1
) (
    input  logic                       clk_i,
    input  logic                       sync_rst_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          data_i,
    output logic [DATA_W-1:0]          data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [TAP_W-1:0]           tap_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;
    logic [PTR_W-1:0]  offs;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // No bypass: a full FIFO refuses a push even when it pops this cycle.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_comb begin
        tap_o = '0;
        offs  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            offs = PTR_W'(i) - rd_ptr_q;
            if (CNT_W'(offs) < count_q) begin
                tap_o = tap_o | mem_q[i][TAP_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/vproc_pipeline_dispatch.sv
// Issue-side dispatcher: queues decoded ops and hands the head op to a capable,
// ready pipeline round-robin once it is free of vreg hazards; drops killed heads.
module vproc_pipeline_dispatch #(
    parameter int unsigned                  PIPE_CNT       = 4,
    parameter int unsigned                  UNIT_CNT       = 6,
    parameter logic [PIPE_CNT*UNIT_CNT-1:0] PIPE_UNIT_MASK = '1,
    parameter int unsigned                  QUEUE_DEPTH    = 4,
    parameter int unsigned                  XIF_ID_W       = 3,
    parameter int unsigned                  XIF_ID_CNT     = 8,
    parameter int unsigned                  PAYLOAD_W      = 64
) (
    input  logic                        clk_i,
    input  logic                        sync_rst_i,
    input  logic                        op_valid_i,
    output logic                        op_ready_o,
    input  logic [$clog2(UNIT_CNT)-1:0] op_unit_i,
    input  logic [XIF_ID_W-1:0]         op_id_i,
    input  logic [31:0]                 op_rd_mask_i,
    input  logic [31:0]                 op_wr_mask_i,
    input  logic [PAYLOAD_W-1:0]        op_payload_i,
    input  logic [31:0]                 vreg_pend_wr_i,
    input  logic [31:0]                 vreg_pend_rd_i,
    input  logic [XIF_ID_CNT-1:0]       instr_killed_i,
    output logic [PIPE_CNT-1:0]         pipe_valid_o,
    input  logic [PIPE_CNT-1:0]         pipe_ready_i,
    output logic [XIF_ID_W-1:0]         pipe_id_o,
    output logic [PAYLOAD_W-1:0]        pipe_payload_o,
    output logic [31:0]                 vreg_pend_wr_o,
    output logic [31:0]                 vreg_pend_rd_o,
    output logic                        drop_valid_o,
    output logic [XIF_ID_W-1:0]         drop_id_o,
    output logic                        queue_empty_o
);

    import vproc_pkg::*;

    localparam int unsigned UNIT_W = $clog2(UNIT_CNT);
    localparam int unsigned PIPE_W = (PIPE_CNT > 1) ? $clog2(PIPE_CNT) : 1;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [XIF_ID_W-1:0]  id;
        logic [UNIT_W-1:0]    unit;
        vreg_masks_t          masks;
    } entry_t;

    entry_t                   push_entry, head;
    vreg_masks_t              fifo_tap;
    logic                     fifo_full, fifo_empty;
    logic [$clog2(QUEUE_DEPTH):0] fifo_count;
    logic                     head_valid, head_killed, hazard, pop, found;
    logic [PIPE_CNT-1:0]      elig;
    logic [PIPE_W-1:0]        rr_ptr_q, rr_ptr_d;
    disp_state_e              state_q, state_d;
    int unsigned              idx;

    assign push_entry = '{payload: op_payload_i, id: op_id_i, unit: op_unit_i,
                          masks: '{wr_mask: op_wr_mask_i, rd_mask: op_rd_mask_i}};

    vproc_dispatch_fifo #(
        .DEPTH  (QUEUE_DEPTH),
        .DATA_W ($bits(entry_t)),
        .TAP_W  ($bits(vreg_masks_t))
    ) u_fifo (
        .clk_i      (clk_i),
        .sync_rst_i (sync_rst_i),
        .push_i     (op_valid_i),
        .pop_i      (pop),
        .data_i     (push_entry),
        .data_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .tap_o      (fifo_tap)
    );

    assign head_valid     = (fifo_count != '0);
    assign op_ready_o     = !fifo_full;
    assign queue_empty_o  = fifo_empty;
    assign vreg_pend_wr_o = fifo_tap.wr_mask;
    assign vreg_pend_rd_o = fifo_tap.rd_mask;
    assign pipe_id_o      = head_valid ? head.id : '0;
    assign pipe_payload_o = head_valid ? head.payload : '0;
    assign head_killed    = instr_killed_i[head.id];
    assign hazard         = vreg_hazard(head.masks, vreg_pend_wr_i, vreg_pend_rd_i);
    assign state_d        = DISP_ARB;

    always_comb begin
        for (int unsigned p = 0; p < PIPE_CNT; p++) begin
            elig[p] = pipe_ready_i[p] && (32'(head.unit) < UNIT_CNT) &&
                      PIPE_UNIT_MASK[p*UNIT_CNT + 32'(head.unit)];
        end
    end

    // Valid is only raised towards a ready pipe, so the handshake always
    // completes in the same cycle and ARB never needs a hold state.
    always_comb begin
        pipe_valid_o = '0;
        drop_valid_o = 1'b0;
        drop_id_o    = '0;
        pop          = 1'b0;
        found        = 1'b0;
        rr_ptr_d     = rr_ptr_q;
        idx          = 0;
        if (state_q == DISP_ARB && head_valid) begin
            if (head_killed) begin
                pop          = 1'b1;
                drop_valid_o = 1'b1;
                drop_id_o    = head.id;
            end else if (!hazard && (elig != '0)) begin
                for (int unsigned k = 0; k < PIPE_CNT; k++) begin
                    idx = (32'(rr_ptr_q) + k) % PIPE_CNT;
                    if (!found && elig[idx]) begin
                        found             = 1'b1;
                        pipe_valid_o[idx] = 1'b1;
                        rr_ptr_d          = PIPE_W'((idx + 1) % PIPE_CNT);
                        pop               = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            rr_ptr_q <= '0;
            state_q  <= DISP_ARB;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= state_d;
        end
    end

endmodule

// File: tb/tb_vproc_pipeline_dispatch.sv
// Bench for vproc_pipeline_dispatch: directed scenarios then random traffic,
// every cycle compared against a queue-based model of the dispatcher.
module tb_vproc_pipeline_dispatch;

    localparam int unsigned NP = 4;
    localparam int unsigned NU = 6;
    localparam int unsigned QD = 4;

    // MUL (unit 2) runs on pipe 2 only; every other unit runs everywhere.
    function automatic logic capable(input int unsigned p, input int unsigned u);
        return (u != 2) || (p == 2);
    endfunction

    function automatic logic [NP*NU-1:0] build_mask();
        logic [NP*NU-1:0] m;
        m = '0;
        for (int unsigned p = 0; p < NP; p++)
            for (int unsigned u = 0; u < NU; u++)
                m[p*NU+u] = capable(p, u);
        return m;
    endfunction

    localparam logic [NP*NU-1:0] MASK = build_mask();

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_ready;
    logic [2:0]  op_unit, op_id;
    logic [31:0] op_rd, op_wr, pend_wr, pend_rd, pend_wr_o, pend_rd_o;
    logic [63:0] op_payload, pipe_payload;
    logic [7:0]  killed;
    logic [3:0]  pipe_valid, pipe_ready;
    logic [2:0]  pipe_id, drop_id;
    logic        drop_valid, queue_empty;

    always #5 clk = ~clk;

    vproc_pipeline_dispatch #(
        .PIPE_CNT       (NP),
        .UNIT_CNT       (NU),
        .PIPE_UNIT_MASK (MASK),
        .QUEUE_DEPTH    (QD),
        .XIF_ID_W       (3),
        .XIF_ID_CNT     (8),
        .PAYLOAD_W      (64)
    ) dut (
        .clk_i          (clk),
        .sync_rst_i     (rst),
        .op_valid_i     (op_valid),
        .op_ready_o     (op_ready),
        .op_unit_i      (op_unit),
        .op_id_i        (op_id),
        .op_rd_mask_i   (op_rd),
        .op_wr_mask_i   (op_wr),
        .op_payload_i   (op_payload),
        .vreg_pend_wr_i (pend_wr),
        .vreg_pend_rd_i (pend_rd),
        .instr_killed_i (killed),
        .pipe_valid_o   (pipe_valid),
        .pipe_ready_i   (pipe_ready),
        .pipe_id_o      (pipe_id),
        .pipe_payload_o (pipe_payload),
        .vreg_pend_wr_o (pend_wr_o),
        .vreg_pend_rd_o (pend_rd_o),
        .drop_valid_o   (drop_valid),
        .drop_id_o      (drop_id),
        .queue_empty_o  (queue_empty)
    );

    typedef struct {
        logic [2:0]  unit;
        logic [2:0]  id;
        logic [31:0] rd;
        logic [31:0] wr;
        logic [63:0] pl;
    } ent_t;

    ent_t        q[$];
    int unsigned rr;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [3:0]  last_pv;
    logic        last_ready, last_drop, last_empty;
    logic [2:0]  last_did;
    logic [31:0] last_prd, last_pwr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are stable from posedge+1; compare at negedge, advance model at posedge.
    task automatic step();
        logic [3:0]  e_pv;
        logic        e_ready, e_drop, pop, hz, found, any_cap;
        logic [2:0]  e_did;
        logic [31:0] e_pw, e_pr;
        int unsigned nrr, p;
        ent_t        h;
        #4;
        e_ready = (q.size() < QD);
        e_pv = '0; e_drop = 1'b0; e_did = '0; pop = 1'b0; found = 1'b0;
        nrr = rr; e_pw = '0; e_pr = '0;
        foreach (q[i]) begin
            e_pw |= q[i].wr;
            e_pr |= q[i].rd;
        end
        if (q.size() > 0) begin
            h = q[0];
            if (killed[h.id]) begin
                e_drop = 1'b1; e_did = h.id; pop = 1'b1;
            end else begin
                hz = ((h.rd & pend_wr) != 0) || ((h.wr & (pend_wr | pend_rd)) != 0);
                for (int unsigned k = 0; k < NP; k++) begin
                    p = (rr + k) % NP;
                    if (!hz && !found && capable(p, h.unit) && pipe_ready[p]) begin
                        found = 1'b1; e_pv = 4'(1 << p); pop = 1'b1; nrr = (p + 1) % NP;
                    end
                end
            end
        end
        if (op_valid) begin
            any_cap = 1'b0;
            for (int unsigned k = 0; k < NP; k++) any_cap |= capable(k, op_unit);
            assert (any_cap) else $error("FAIL stall_unit unit=%0d has no capable pipe", op_unit);
        end
        chk("op_ready", op_ready, e_ready);
        chk("pipe_valid", pipe_valid, e_pv);
        chk("queue_empty", queue_empty, q.size() == 0);
        chk("pend_wr", pend_wr_o, e_pw);
        chk("pend_rd", pend_rd_o, e_pr);
        chk("drop_valid", drop_valid, e_drop);
        if (e_drop) chk("drop_id", drop_id, e_did);
        if (e_pv != 0) begin
            chk("pipe_id", pipe_id, q[0].id);
            chk("pipe_payload", pipe_payload, q[0].pl);
        end
        last_pv = pipe_valid; last_ready = op_ready; last_drop = drop_valid;
        last_did = drop_id; last_empty = queue_empty; last_prd = pend_rd_o; last_pwr = pend_wr_o;
        @(posedge clk);
        if (rst) begin
            q.delete();
            rr = 0;
        end else begin
            if (pop) void'(q.pop_front());
            rr = nrr;
            if (op_valid && e_ready)
                q.push_back('{unit: op_unit, id: op_id, rd: op_rd, wr: op_wr, pl: op_payload});
        end
        #1;
    endtask

    task automatic idle();
        op_valid = 1'b0; pend_wr = '0; pend_rd = '0; killed = '0; pipe_ready = 4'hf;
    endtask

    task automatic set_op(input logic [2:0] u, input logic [2:0] id,
                          input logic [31:0] rd, input logic [31:0] wr);
        op_valid = 1'b1; op_unit = u; op_id = id; op_rd = rd; op_wr = wr;
        op_payload = {$urandom(), $urandom()};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] hist[5];
        rst = 1'b1; rr = 0;
        idle();
        op_unit = '0; op_id = '0; op_rd = '0; op_wr = '0; op_payload = '0;
        @(posedge clk); #1;
        step();
        chk("reset_ready", last_ready, 1'b1);
        chk("reset_empty", last_empty, 1'b1);
        step();
        rst = 1'b0;

        // Round-robin across four ready pipes
        for (int i = 0; i < 4; i++) begin
            set_op(3'd1, 3'(i), '0, '0);
            step();
            hist[i] = last_pv;
            chk("rr_ready", last_ready, 1'b1);
        end
        idle();
        step();
        hist[4] = last_pv;
        chk("rr_c0", hist[0], 4'b0000);
        chk("rr_c1", hist[1], 4'b0001);
        chk("rr_c2", hist[2], 4'b0010);
        chk("rr_c3", hist[3], 4'b0100);
        chk("rr_c4", hist[4], 4'b1000);

        // Full queue: a pop does not free a slot until the next cycle
        pipe_ready = 4'h0;
        for (int i = 0; i < 4; i++) begin
            set_op(3'd1, 3'(i), '0, '0);
            step();
        end
        set_op(3'd1, 3'd4, '0, '0);
        step();
        chk("full_ready", last_ready, 1'b0);
        pipe_ready = 4'b0001;
        step();
        chk("pop_full_ready", last_ready, 1'b0);
        chk("pop_full_pv", last_pv, 4'b0001);
        step();
        chk("after_pop_ready", last_ready, 1'b1);
        idle();
        repeat (6) step();

        // Read-after-write hazard holds the head
        pend_wr = 32'h4;
        set_op(3'd1, 3'd1, 32'h4, '0);
        step();
        op_valid = 1'b0;
        repeat (3) begin
            step();
            chk("hz_hold", last_pv, 4'b0000);
            chk("hz_pend_rd", last_prd, 32'h4);
        end
        pend_wr = '0;
        step();
        chk("hz_release_pend_rd", last_prd, 32'h4);
        chk("hz_release_any", last_pv != 0, 1'b1);
        step();

        // Killed entry behind the head is dropped when it reaches the head
        pipe_ready = 4'h0; killed = 8'b0000_1000;
        set_op(3'd1, 3'd2, '0, '0); step();
        set_op(3'd1, 3'd3, '0, '0); step();
        set_op(3'd1, 3'd5, '0, '0); step();
        op_valid = 1'b0; pipe_ready = 4'hf;
        step();
        chk("kill_c0_disp", last_pv != 0, 1'b1);
        step();
        chk("kill_c1_drop", last_drop, 1'b1);
        chk("kill_c1_id", last_did, 3'd3);
        chk("kill_c1_pv", last_pv, 4'b0000);
        step();
        chk("kill_c2_disp", last_pv != 0, 1'b1);
        idle();
        step();

        // Restricted unit: MUL must land on pipe 2, next op then on pipe 3
        set_op(3'd2, 3'd6, '0, '0); step();
        set_op(3'd1, 3'd7, '0, '0); step();
        chk("mul_pipe", last_pv, 4'b0100);
        op_valid = 1'b0;
        step();
        chk("after_mul_pipe", last_pv, 4'b1000);
        step();

        // Reset with entries queued
        pipe_ready = 4'h0;
        for (int i = 0; i < 3; i++) begin
            set_op(3'd1, 3'(i), 32'(1) << i, 32'(1) << (i + 8));
            step();
        end
        op_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; pipe_ready = 4'hf;
        step();
        chk("rst_empty", last_empty, 1'b1);
        chk("rst_pend_wr", last_pwr, 32'h0);
        chk("rst_pend_rd", last_prd, 32'h0);
        chk("rst_pv", last_pv, 4'b0000);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            op_valid = ($urandom_range(0, 2) != 0);
            op_unit = 3'($urandom_range(0, NU - 1));
            op_id = 3'($urandom);
            op_rd = ($urandom_range(0, 2) == 0) ? (32'(1) << $urandom_range(0, 31)) : '0;
            op_wr = ($urandom_range(0, 2) == 0) ? (32'(1) << $urandom_range(0, 31)) : '0;
            op_payload = {$urandom(), $urandom()};
            pend_wr = ($urandom_range(0, 3) == 0) ? (32'(1) << $urandom_range(0, 31)) : '0;
            pend_rd = ($urandom_range(0, 3) == 0) ? (32'(1) << $urandom_range(0, 31)) : '0;
            killed = ($urandom_range(0, 7) == 0) ? 8'(1 << $urandom_range(0, 7)) : '0;
            pipe_ready = 4'($urandom);
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
